// File: rtl/sampler_pkg.sv
// Shared types and constants for the constrained-random sample generator.
package sampler_pkg;

  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_CHECK = 3'd2,
    ST_PUSH  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_e;

  // Galois right-shift LFSR step; feedback taps folded in when the LSB falls out.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] fb;
    if (s[0]) begin
      fb = LFSR_POLY;
    end else begin
      fb = '0;
    end
    return (s >> 1) ^ fb;
  endfunction

  // An all-zero state would lock the LFSR, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] lfsr_sanitize(input logic [LFSR_W-1:0] s);
    if (s == '0) begin
      return {{(LFSR_W-1){1'b0}}, 1'b1};
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through buffer for accepted samples. A pop in the same
// cycle as a push while full does not make room for that push.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + CW'(1);
    end else if (!do_push_s && do_pop_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Register FIFO state; reset empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sample_generator.sv
// Generates LFSR candidates, has an external checker accept or reject them,
// and buffers accepted candidates until the requested count is reached.
module sample_generator
  import sampler_pkg::*;
#(
  parameter int          VEC_W      = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_TRIES  = 1024,
  parameter logic [31:0] SEED       = 32'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_samples,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  output logic [VEC_W-1:0] cand_vec,
  output logic             cand_valid,
  input  logic             chk_x,
  output logic [VEC_W-1:0] smp_data,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [31:0]      tries
);

  localparam int NW  = (VEC_W + LFSR_W - 1) / LFSR_W;
  localparam int BW  = NW * LFSR_W;
  localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [31:0] MAX_TRIES_C = 32'(MAX_TRIES);
  localparam logic [31:0] SEED_INIT   = (SEED == 32'h0) ? 32'h1 : SEED;

  state_e          state_q, state_d;
  logic [31:0]     lfsr_q, lfsr_d;
  logic [BW-1:0]   gbuf_q, gbuf_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [31:0]     tries_q, tries_d;
  logic [15:0]     acc_q, acc_d;
  logic [15:0]     num_q, num_d;
  logic            cand_valid_q, cand_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic [31:0]     lfsr_next_s;
  logic            push_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;

  assign cand_vec   = gbuf_q[VEC_W-1:0];
  assign cand_valid = cand_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign tries      = tries_q;
  assign smp_valid  = !fifo_empty_s;

  // Next-state logic for the run sequencer and its datapath.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    gbuf_d      = gbuf_q;
    wcnt_d      = wcnt_q;
    tries_d     = tries_q;
    acc_d       = acc_q;
    num_d       = num_q;
    push_s      = 1'b0;
    lfsr_next_s = lfsr_step(lfsr_q);
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        // Seed lands before a same-cycle start so the run uses it.
        if (seed_load) begin
          lfsr_d = lfsr_sanitize(seed);
        end else begin
          lfsr_d = lfsr_q;
        end
        if (start) begin
          num_d = num_samples;
          if (num_samples == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            tries_d = 32'd0;
            acc_d   = 16'd0;
            wcnt_d  = '0;
            state_d = ST_GEN;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_GEN: begin
        // Newest LFSR word enters at the top; earlier words slide toward the LSBs.
        lfsr_d                  = lfsr_next_s;
        gbuf_d                  = gbuf_q >> LFSR_W;
        gbuf_d[BW-1 -: LFSR_W]  = lfsr_next_s;
        if (wcnt_q == WCW'(NW - 1)) begin
          wcnt_d  = '0;
          state_d = ST_CHECK;
        end else begin
          wcnt_d  = wcnt_q + WCW'(1);
          state_d = ST_GEN;
        end
      end
      ST_CHECK: begin
        if (tries_q == 32'hFFFF_FFFF) begin
          tries_d = tries_q;
        end else begin
          tries_d = tries_q + 32'd1;
        end
        if (chk_x) begin
          state_d = ST_PUSH;
        end else if (tries_d >= MAX_TRIES_C) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_GEN;
        end
      end
      ST_PUSH: begin
        if (!fifo_full_s) begin
          push_s = 1'b1;
          acc_d  = acc_q + 16'd1;
          if ((acc_q + 16'd1) == num_q) begin
            state_d = ST_DONE;
          end else if (tries_q >= MAX_TRIES_C) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_GEN;
          end
        end else begin
          state_d = ST_PUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cand_valid_d = (state_d == ST_CHECK);
    busy_d       = (state_d == ST_GEN) || (state_d == ST_CHECK) || (state_d == ST_PUSH);
    done_d       = (state_d == ST_DONE);
    fail_d       = (state_d == ST_FAIL);
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= SEED_INIT;
      gbuf_q       <= '0;
      wcnt_q       <= '0;
      tries_q      <= 32'd0;
      acc_q        <= 16'd0;
      num_q        <= 16'd0;
      cand_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      gbuf_q       <= gbuf_d;
      wcnt_q       <= wcnt_d;
      tries_q      <= tries_d;
      acc_q        <= acc_d;
      num_q        <= num_d;
      cand_valid_q <= cand_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
    end
  end

  sample_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (gbuf_q[VEC_W-1:0]),
    .full  (fifo_full_s),
    .pop   (smp_ready),
    .empty (fifo_empty_s),
    .dout  (smp_data)
  );

endmodule
